// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel and packed window formats used by the window builder
// and the downstream window convolver.
package cnn_pkg;

    localparam int WIN_MAX  = 25;
    localparam int FS_SMALL = 3;
    localparam int FS_LARGE = 5;

    typedef logic signed [15:0] pixel_t;
    typedef pixel_t [0:WIN_MAX-1] window_t;
    typedef pixel_t [0:FS_LARGE-1] win_row_t;
    typedef win_row_t [0:FS_LARGE-1] win_grid_t;

    // A 3x3 window is the bottom-right corner of the 5x5 grid (newest rows and columns).
    function automatic window_t pack_window(input win_grid_t grid, input logic fs_large);
        window_t w;
        w = '0;
        if (fs_large) begin
            for (int r = 0; r < FS_LARGE; r++)
                for (int c = 0; c < FS_LARGE; c++)
                    w[r*FS_LARGE + c] = grid[r][c];
        end else begin
            for (int r = 0; r < FS_SMALL; r++)
                for (int c = 0; c < FS_SMALL; c++)
                    w[r*FS_SMALL + c] = grid[r + FS_LARGE - FS_SMALL][c + FS_LARGE - FS_SMALL];
        end
        return w;
    endfunction

endpackage

// File: rtl/window_builder_if.sv
// Frame control, pixel input and window output handshake of the window builder.
// WB_STRIDE2_EN adds the stride select input.
interface window_builder_if;
    import cnn_pkg::*;

    logic        start;
    logic [15:0] imageSize;
    logic [15:0] filterSize;
`ifdef WB_STRIDE2_EN
    logic        stride;
`endif
    logic        in_valid;
    logic        in_ready;
    pixel_t      in_pixel;
    logic        out_valid;
    logic        out_ready;
    window_t     window;
    logic        busy;
    logic        done;

    modport slave (
`ifdef WB_STRIDE2_EN
        input  stride,
`endif
        input  start, imageSize, filterSize, in_valid, in_pixel, out_ready,
        output in_ready, out_valid, window, busy, done
    );

    modport master (
`ifdef WB_STRIDE2_EN
        output stride,
`endif
        output start, imageSize, filterSize, in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, window, busy, done
    );

endinterface

// File: rtl/line_buffer.sv
// Single-port row buffer: combinational read of the addressed entry and a write to the
// same address on the clock edge, so a shift reads the previous row before overwriting it.
module line_buffer #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

endmodule

// File: rtl/window_builder.sv
// Raster-order pixel stream to 3x3/5x5 sliding window (valid-only, no padding).
// Build option WB_STRIDE2_EN adds a runtime stride-2 mode selected at frame start.
//
// state   | meaning
// S_IDLE  | waiting for start; no pixels accepted
// S_RUN   | accepting pixels, emitting windows with 1-cycle latency
// S_DRAIN | last pixel taken; waiting for the final window to leave, then done
module window_builder
    import cnn_pkg::*;
#(
    parameter int MAX_WIDTH = 32,
    parameter int DATA_W    = 16
) (
    input logic             clk,
    input logic             rst,
    window_builder_if.slave wb
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int NLB = FS_LARGE - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] w_q, w_d;
    logic [15:0] row_q, row_d;
    logic [15:0] col_q, col_d;
    logic        fs_large_q, fs_large_d;
    logic        out_valid_q, out_valid_d;
    window_t     window_q, window_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    win_grid_t   sr_q, sr_d, sr_next;

    pixel_t      lb_wr [NLB];
    pixel_t      lb_rd [NLB];
    logic        in_ready;
    logic        accept;
    logic        emit;
    logic        stride_en;
    logic [15:0] fs_m1;

`ifdef WB_STRIDE2_EN
    logic stride_q, stride_d;

    always_comb begin
        stride_d = stride_q;
        if (state_q == S_IDLE && wb.start) stride_d = wb.stride;
    end

    always_ff @(posedge clk) begin
        if (rst) stride_q <= 1'b0;
        else     stride_q <= stride_d;
    end

    assign stride_en = stride_q;
`else
    assign stride_en = 1'b0;
`endif

    assign in_ready = (state_q == S_RUN) && (!out_valid_q || wb.out_ready);
    assign accept   = wb.in_valid && in_ready;
    assign fs_m1    = fs_large_q ? 16'(FS_LARGE - 1) : 16'(FS_SMALL - 1);

    // fs-1 is even, so the window origin is even exactly when row/col are even.
    assign emit = accept && (row_q >= fs_m1) && (col_q >= fs_m1) &&
                  (!stride_en || (!row_q[0] && !col_q[0]));

    for (genvar k = 0; k < NLB; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign lb_wr[k] = wb.in_pixel;
        end else begin : g_tail
            assign lb_wr[k] = lb_rd[k-1];
        end

        line_buffer #(
            .DEPTH  (MAX_WIDTH),
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (col_q[AW-1:0]),
            .wdata (lb_wr[k]),
            .rdata (lb_rd[k])
        );
    end

    // Grid row 0 is the oldest row (deepest line buffer), row 4 the incoming pixel.
    always_comb begin
        sr_next = sr_q;
        for (int r = 0; r < FS_LARGE; r++)
            for (int c = 0; c < FS_LARGE - 1; c++)
                sr_next[r][c] = sr_q[r][c+1];
        for (int r = 0; r < NLB; r++)
            sr_next[r][FS_LARGE-1] = lb_rd[NLB-1-r];
        sr_next[FS_LARGE-1][FS_LARGE-1] = wb.in_pixel;
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        fs_large_d  = fs_large_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        window_d    = window_q;
        done_d      = 1'b0;
        sr_d        = sr_q;

        case (state_q)
            S_IDLE: begin
                if (wb.start) begin
                    state_d    = S_RUN;
                    w_d        = (wb.imageSize > 16'(MAX_WIDTH)) ? 16'(MAX_WIDTH) : wb.imageSize;
                    fs_large_d = (wb.filterSize != 16'(FS_SMALL));
                    row_d      = '0;
                    col_d      = '0;
                end
            end
            S_RUN: begin
                if (out_valid_q && wb.out_ready) out_valid_d = 1'b0;
                if (accept) begin
                    sr_d = sr_next;
                    if (emit) begin
                        out_valid_d = 1'b1;
                        window_d    = pack_window(sr_next, fs_large_q);
                    end
                    if (col_q == w_q - 16'd1) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                        if (row_q == w_q - 16'd1) state_d = S_DRAIN;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || wb.out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            w_q         <= '0;
            fs_large_q  <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            window_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            fs_large_q  <= fs_large_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            window_q    <= window_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Window shift register is pure datapath; stale columns are never emitted.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign wb.in_ready  = in_ready;
    assign wb.out_valid = out_valid_q;
    assign wb.window    = window_q;
    assign wb.busy      = busy_q;
    assign wb.done      = done_q;

endmodule

// File: tb/tb_window_builder.sv
// Randomized bench for window_builder: expected windows are enumerated from the pixel
// frame by top-left position and compared in order against the accepted output stream.
module tb_window_builder;
    import cnn_pkg::*;

    localparam int MAXW = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    window_builder_if bus ();

    window_builder #(
        .MAX_WIDTH (MAXW),
        .DATA_W    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input int w, input int fs_in, input bit strd, input bit seq_px,
                             input int vprob, input int rmode, input int abort_at,
                             input bit stray);
        pixel_t  px [$];
        window_t exp_q [$];
        window_t x;
        int  we, fs, n_px, n_exp, span, p, r, c, cyc, limit, got_n;
        int  done_cyc, last_acc, last_pix, dn;
        bit  pend_new, px_acc, win_acc, stray_done, abort_now;

        we   = (w > MAXW) ? MAXW : w;
        fs   = (fs_in == 3) ? 3 : 5;
        n_px = we * we;
        for (int i = 0; i < n_px; i++)
            px.push_back(seq_px ? pixel_t'(i) : pixel_t'($urandom_range(0, 65535)));
        for (int r0 = 0; r0 + fs <= we; r0++)
            for (int c0 = 0; c0 + fs <= we; c0++)
                if (!strd || (r0 % 2 == 0 && c0 % 2 == 0)) begin
                    x = '0;
                    for (int i = 0; i < fs; i++)
                        for (int j = 0; j < fs; j++)
                            x[i*fs + j] = px[(r0 + i)*we + c0 + j];
                    exp_q.push_back(x);
                end
        span  = we - fs + 1;
        n_exp = (we < fs) ? 0 : (strd ? ((span + 1) / 2) * ((span + 1) / 2) : span * span);

        @(negedge clk);
        bus.start      = 1'b1;
        bus.imageSize  = 16'(w);
        bus.filterSize = 16'(fs_in);
`ifdef WB_STRIDE2_EN
        bus.stride     = strd;
`endif
        @(negedge clk);
        bus.start = 1'b0;

        p = 0; cyc = 0; got_n = 0; pend_new = 0; stray_done = 0; abort_now = 0;
        done_cyc = -1; last_acc = -1; last_pix = -1;
        limit = n_px * 30 + 100;
        while (cyc < limit) begin
            if (pend_new) chk("win_latency", bus.out_valid, 1'b1);
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            chk("busy_in_frame", bus.busy, 1'b1);

            bus.in_valid = (p < n_px) && ($urandom_range(0, 99) < vprob);
            bus.in_pixel = (p < n_px) ? px[p] : pixel_t'(0);
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            bus.start = stray && !stray_done && (p == n_px / 2);
            if (bus.start) begin
                stray_done    = 1;
                bus.imageSize = 16'd3;
            end
            #1;
            px_acc  = bus.in_valid && bus.in_ready;
            win_acc = bus.out_valid && bus.out_ready;
            if (bus.out_valid) begin
                chk("window_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk("window", bus.window, exp_q[0]);
                if (!bus.out_ready) chk("in_ready_held", bus.in_ready, 1'b0);
            end
            if (win_acc) begin
                got_n++;
                last_acc = cyc;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            pend_new = 0;
            if (px_acc) begin
                r = p / we;
                c = p % we;
                pend_new = (r >= fs - 1) && (c >= fs - 1) &&
                           (!strd || ((r - fs + 1) % 2 == 0 && (c - fs + 1) % 2 == 0));
                p++;
                if (p == n_px) last_pix = cyc;
                if (p == abort_at) abort_now = 1;
            end

            @(negedge clk);
            cyc++;
            bus.start = 1'b0;

            if (abort_now) begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_in_ready", bus.in_ready, 1'b0);
                chk("rst_out_valid", bus.out_valid, 1'b0);
                chk("rst_window", bus.window, '0);
                chk("rst_busy", bus.busy, 1'b0);
                chk("rst_done", bus.done, 1'b0);
                dn = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.done) dn++;
                end
                chk("no_done_after_rst", dn, 0);
                return;
            end
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("done_seen", done_cyc >= 0, 1'b1);
        chk("all_pixels", p, n_px);
        chk("win_count", got_n, n_exp);
        if (done_cyc >= 0) begin
            if (n_exp == 0)      chk("done_latency", done_cyc, last_pix + 2);
            else if (!strd)      chk("done_latency", done_cyc, last_acc + 1);
            @(negedge clk);
            chk("done_pulse", bus.done, 1'b0);
            chk("idle_busy", bus.busy, 1'b0);
            chk("idle_in_ready", bus.in_ready, 1'b0);
        end else begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        int fs_opts [4];
        fs_opts = '{3, 5, 7, 0};
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.imageSize  = '0;
        bus.filterSize = '0;
        bus.in_valid   = 1'b0;
        bus.in_pixel   = '0;
        bus.out_ready  = 1'b0;
`ifdef WB_STRIDE2_EN
        bus.stride     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", bus.in_ready, 1'b0);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_window", bus.window, '0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);

        run_frame(5, 3, 0, 1, 100, 0, -1, 0);
        run_frame(5, 5, 0, 1, 100, 0, -1, 0);
        run_frame(6, 3, 0, 1, 100, 1, -1, 0);
        run_frame(2, 3, 0, 1, 100, 0, -1, 0);
        run_frame(5, 3, 0, 1, 100, 0, 11, 0);
        run_frame(5, 3, 0, 1, 100, 0, -1, 0);
        for (int i = 0; i < 6; i++)
            run_frame($urandom_range(1, 40), fs_opts[$urandom_range(0, 3)], 0, 0,
                      $urandom_range(50, 100), 2, -1, i == 2);
`ifdef WB_STRIDE2_EN
        run_frame(7, 3, 1, 1, 100, 0, -1, 0);
        run_frame($urandom_range(5, 20), fs_opts[$urandom_range(0, 1)], 1, 0, 70, 2, -1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
